instr_fetch_responder: RTL and testbench

- Instruction-side responder for the PC/branch unit. It consumes `pcir_cs` (active-low "opcode consumed, new PC presented") and `program_count`.
- It fetches the addressed word from instruction memory over a variable-latency read port and returns `opcode` with `finish`=1 (FULL) when the opcode is valid.
- A one-entry tag holds the last fetched PC/opcode pair. Branch and jump stalls re-present an unchanged PC, and these are served without a memory access.
- Misaligned PCs and memory timeouts raise a sticky fault.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_fetch_responder_if.sv | 24 ++
 rtl/fetch_tag_reg.sv | 33 +++
 rtl/instr_fetch_responder.sv | 99 +++++++++
 tb/tb_instr_fetch_responder.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU handshake constants and the instruction-fetch state encoding.
package cpu_pkg;

  // Handshake levels shared with the PC/branch unit.
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;
  localparam logic FULL     = 1'b1;
  localparam logic EMPTY    = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_FAULT
  } fetch_state_e;

  // Instruction addresses must be 32-bit word aligned.
  function automatic logic word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_responder_if.sv
// PC-unit handshake plus instruction-memory read port of the fetch responder.
interface instr_fetch_responder_if;
  logic        pcir_cs;
  logic [31:0] program_count;
  logic [31:0] opcode;
  logic        finish;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        fault;

  // Fetch responder side.
  modport slave (
    input  pcir_cs, program_count, imem_rdata, imem_ready,
    output opcode, finish, imem_rd_en, imem_addr, fault
  );

  // Environment side: PC unit and instruction memory.
  modport master (
    output pcir_cs, program_count, imem_rdata, imem_ready,
    input  opcode, finish, imem_rd_en, imem_addr, fault
  );
endinterface

// File: rtl/fetch_tag_reg.sv
// One-entry tag/data/valid register remembering the last fetched PC/opcode pair.
module fetch_tag_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_tag,
  input  logic [31:0] wr_data,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] rd_data
);

  logic        valid_q;
  logic [31:0] tag_q;
  logic [31:0] data_q;

  // Entry is overwritten on every write; only reset invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
      tag_q   <= wr_tag;
      data_q  <= wr_data;
    end
  end

  assign hit     = valid_q && (tag_q == lookup_addr);
  assign rd_data = data_q;

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: serves PC requests from a one-entry tag or
// from a variable-latency instruction memory, with a sticky fault state.
module instr_fetch_responder
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_fetch_responder_if.slave   bus
);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;
  logic [31:0]       opcode_q, opcode_d;
  logic [31:0]       addr_q, addr_d;
  logic              tag_wr;
  logic              tag_hit;
  logic [31:0]       tag_data;

  fetch_tag_reg u_tag (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (tag_wr),
    .wr_tag      (addr_q),
    .wr_data     (bus.imem_rdata),
    .lookup_addr (bus.program_count),
    .hit         (tag_hit),
    .rd_data     (tag_data)
  );

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // State, wait counter, opcode and read-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opcode_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
    end
  end

  // Next-state logic; ready takes priority over the timeout in S_WAIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    tag_wr   = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_SYNC;
      S_SYNC: begin
        if (!word_aligned(bus.program_count[1:0])) begin
          state_d = S_FAULT;
        end else if (tag_hit) begin
          opcode_d = tag_data;
          state_d  = S_VALID;
        end else begin
          addr_d  = bus.program_count;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_ready) begin
          opcode_d = bus.imem_rdata;
          tag_wr   = 1'b1;
          state_d  = S_VALID;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_inc[CNT_W-1:0];
          if (cnt_inc >= (CNT_W+1)'(TIMEOUT)) state_d = S_FAULT;
        end
      end
      S_VALID: begin
        if (bus.pcir_cs == ACTIVE) state_d = S_SYNC;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.opcode     = opcode_q;
  assign bus.imem_addr  = addr_q;
  assign bus.finish     = (state_q == S_VALID) ? FULL : EMPTY;
  assign bus.imem_rd_en = (state_q == S_REQ);
  assign bus.fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed, table-driven bench for instr_fetch_responder.
module tb_instr_fetch_responder;

  typedef struct {
    logic        rst;
    logic        pcir_cs;
    logic [31:0] pc;
    logic        ready;
    logic [31:0] rdata;
    logic        e_fin;
    logic [31:0] e_op;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_flt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_to;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  instr_fetch_responder_if bus();
  instr_fetch_responder_if bus_to();

  instr_fetch_responder #(.TIMEOUT(255), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_fetch_responder #(.TIMEOUT(4), .CNT_W(8)) u_dut_to (
    .clk (clk),
    .rst (rst_to),
    .bus (bus_to)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic cs, input logic [31:0] pc,
                     input logic rdy, input logic [31:0] rd,
                     input logic fin, input logic [31:0] op, input logic rden,
                     input logic [31:0] addr, input logic flt);
    vec_t v;
    v.rst = r; v.pcir_cs = cs; v.pc = pc; v.ready = rdy; v.rdata = rd;
    v.e_fin = fin; v.e_op = op; v.e_rd = rden; v.e_addr = addr; v.e_flt = flt;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    rst_to = 1'b1;
    bus.pcir_cs = 1'b1; bus.program_count = '0; bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    bus_to.pcir_cs = 1'b1; bus_to.program_count = 32'h8; bus_to.imem_ready = 1'b0;
    bus_to.imem_rdata = '0;

    // rst cs pc rdy rdata | finish opcode rd_en addr fault
    add(1,1,32'h0,0,32'h0,            0,32'h0,0,32'h0,0);          // reset
    add(1,1,32'h0,0,32'h0,            0,32'h0,0,32'h0,0);
    add(0,1,32'h0,0,32'h0,            0,32'h0,0,32'h0,0);          // SYNC
    add(0,1,32'h0,0,32'h0,            0,32'h0,1,32'h0,0);          // REQ, miss
    add(0,1,32'h0,1,32'hBAD0_0001,    0,32'h0,0,32'h0,0);          // ready in REQ ignored
    add(0,1,32'h0,1,32'h2008_0005,    1,32'h2008_0005,0,32'h0,0);  // VALID at cycle 4
    add(0,1,32'h0,1,32'hBAD0_0002,    1,32'h2008_0005,0,32'h0,0);  // ready outside WAIT
    add(0,0,32'h0,0,32'h0,            0,32'h2008_0005,0,32'h0,0);  // stall -> SYNC
    add(0,1,32'h0,0,32'h0,            1,32'h2008_0005,0,32'h0,0);  // hit
    add(0,0,32'h40,0,32'h0,           0,32'h2008_0005,0,32'h0,0);  // SYNC
    add(0,1,32'h40,0,32'h0,           0,32'h2008_0005,1,32'h40,0); // REQ
    add(0,1,32'h40,0,32'h0,           0,32'h2008_0005,0,32'h40,0); // WAIT
    for (int i = 0; i < 5; i++)                                     // 5 wait states
      add(0,0,32'h80,0,32'h0,         0,32'h2008_0005,0,32'h40,0);
    add(0,1,32'h80,1,32'h0800_0010,   1,32'h0800_0010,0,32'h40,0); // cycle 9
    add(0,0,32'h0,0,32'h0,            0,32'h0800_0010,0,32'h40,0); // SYNC
    add(0,1,32'h0,0,32'h0,            0,32'h0800_0010,1,32'h0,0);  // tag replaced -> miss
    add(0,1,32'h0,0,32'h0,            0,32'h0800_0010,0,32'h0,0);
    add(0,1,32'h0,1,32'h1234_5678,    1,32'h1234_5678,0,32'h0,0);
    add(0,0,32'hFFFF_FFFC,0,32'h0,    0,32'h1234_5678,0,32'h0,0);  // top address
    add(0,1,32'hFFFF_FFFC,0,32'h0,    0,32'h1234_5678,1,32'hFFFF_FFFC,0);
    add(0,1,32'hFFFF_FFFC,0,32'h0,    0,32'h1234_5678,0,32'hFFFF_FFFC,0);
    add(0,1,32'hFFFF_FFFC,1,32'hAABB_CCDD, 1,32'hAABB_CCDD,0,32'hFFFF_FFFC,0);
    add(0,0,32'hFFFF_FFFC,0,32'h0,    0,32'hAABB_CCDD,0,32'hFFFF_FFFC,0);
    add(0,1,32'hFFFF_FFFC,0,32'h0,    1,32'hAABB_CCDD,0,32'hFFFF_FFFC,0); // hit
    add(0,0,32'h42,0,32'h0,           0,32'hAABB_CCDD,0,32'hFFFF_FFFC,0); // SYNC
    add(0,1,32'h42,0,32'h0,           0,32'hAABB_CCDD,0,32'hFFFF_FFFC,1); // misaligned
    add(0,0,32'h0,1,32'hBAD0_0003,    0,32'hAABB_CCDD,0,32'hFFFF_FFFC,1); // sticky
    add(0,0,32'h0,1,32'hBAD0_0003,    0,32'hAABB_CCDD,0,32'hFFFF_FFFC,1);
    add(1,1,32'h0,0,32'h0,            0,32'h0,0,32'h0,0);          // reset clears fault
    add(0,1,32'h100,0,32'h0,          0,32'h0,0,32'h0,0);          // SYNC
    add(0,1,32'h100,0,32'h0,          0,32'h0,1,32'h100,0);        // REQ
    add(0,1,32'h100,0,32'h0,          0,32'h0,0,32'h100,0);        // WAIT
    add(1,1,32'h100,0,32'h0,          0,32'h0,0,32'h0,0);          // reset mid-fetch
    add(0,1,32'h100,1,32'hDEAD_BEEF,  0,32'h0,0,32'h0,0);          // late ready ignored
    add(0,1,32'h100,0,32'h0,          0,32'h0,1,32'h100,0);        // tag invalid -> miss
    add(0,1,32'h100,0,32'h0,          0,32'h0,0,32'h100,0);
    add(0,1,32'h100,1,32'h1111_2222,  1,32'h1111_2222,0,32'h100,0);

    foreach (vecs[i]) begin
      rst               = vecs[i].rst;
      bus.pcir_cs       = vecs[i].pcir_cs;
      bus.program_count = vecs[i].pc;
      bus.imem_ready    = vecs[i].ready;
      bus.imem_rdata    = vecs[i].rdata;
      tick();
      chk($sformatf("v%0d finish", i), 32'(bus.finish),     32'(vecs[i].e_fin));
      chk($sformatf("v%0d opcode", i), bus.opcode,          vecs[i].e_op);
      chk($sformatf("v%0d rd_en", i),  32'(bus.imem_rd_en), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d addr", i),   bus.imem_addr,       vecs[i].e_addr);
      chk($sformatf("v%0d fault", i),  32'(bus.fault),      32'(vecs[i].e_flt));
    end

    // Timeout with TIMEOUT=4: fault after the fourth ready-less S_WAIT cycle.
    rst_to = 1'b1;
    tick(); tick();
    chk("to reset fault", 32'(bus_to.fault), 32'h0);
    rst_to = 1'b0;
    tick();                                   // SYNC
    tick();                                   // REQ
    chk("to rd_en", 32'(bus_to.imem_rd_en), 32'h1);
    chk("to addr", bus_to.imem_addr, 32'h8);
    tick();                                   // WAIT entered
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("to wait%0d fault", i), 32'(bus_to.fault), 32'h0);
    end
    tick();
    chk("to fault", 32'(bus_to.fault), 32'h1);
    chk("to finish", 32'(bus_to.finish), 32'h0);
    bus_to.imem_ready = 1'b1;
    bus_to.imem_rdata = 32'h5555_AAAA;
    bus_to.pcir_cs    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("to late%0d fault", i), 32'(bus_to.fault), 32'h1);
      chk($sformatf("to late%0d finish", i), 32'(bus_to.finish), 32'h0);
      chk($sformatf("to late%0d opcode", i), bus_to.opcode, 32'h0);
      chk($sformatf("to late%0d rd_en", i), 32'(bus_to.imem_rd_en), 32'h0);
    end

    // Ready in the same cycle the counter reaches TIMEOUT: fetch succeeds.
    bus_to.pcir_cs    = 1'b1;
    bus_to.imem_ready = 1'b0;
    rst_to = 1'b1;
    tick();
    chk("rw reset fault", 32'(bus_to.fault), 32'h0);
    rst_to = 1'b0;
    tick(); tick(); tick();                   // SYNC, REQ, WAIT
    for (int i = 0; i < 3; i++) tick();
    chk("rw pre fault", 32'(bus_to.fault), 32'h0);
    bus_to.imem_ready = 1'b1;
    bus_to.imem_rdata = 32'h600D_F00D;
    tick();
    chk("rw finish", 32'(bus_to.finish), 32'h1);
    chk("rw fault", 32'(bus_to.fault), 32'h0);
    chk("rw opcode", bus_to.opcode, 32'h600D_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
